// File: rtl/turn_signal_pkg.sv
// Shared types, codes and decode helpers for the tail-light turn-signal scheduler.
// State encoding, request arbitration and lamp/mode decoding live here.
package turn_signal_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_L1      = 4'd1,
        ST_L2      = 4'd2,
        ST_L3      = 4'd3,
        ST_R1      = 4'd4,
        ST_R2      = 4'd5,
        ST_R3      = 4'd6,
        ST_GAP     = 4'd7,
        ST_HAZ_ON  = 4'd8,
        ST_HAZ_OFF = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_LEFT  = 2'd1,
        REQ_RIGHT = 2'd2,
        REQ_HAZ   = 2'd3
    } req_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_HAZ   = 2'b11;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_1   = 3'b001;
    localparam logic [2:0] LAMP_2   = 3'b011;
    localparam logic [2:0] LAMP_3   = 3'b111;

    // Hazard wins; left and right together cancel each other out.
    function automatic req_t arbitrate(input logic hazard, input logic turn_on,
                                       input logic left, input logic right);
        req_t sel;
        if (hazard) begin
            sel = REQ_HAZ;
        end else if (turn_on && left && !right) begin
            sel = REQ_LEFT;
        end else if (turn_on && right && !left) begin
            sel = REQ_RIGHT;
        end else begin
            sel = REQ_NONE;
        end
        return sel;
    endfunction

    function automatic state_t entry_state(input req_t sel);
        state_t st;
        case (sel)
            REQ_HAZ:   st = ST_HAZ_ON;
            REQ_LEFT:  st = ST_L1;
            REQ_RIGHT: st = ST_R1;
            default:   st = ST_IDLE;
        endcase
        return st;
    endfunction

    // Step taken by a sweep (or the gap after it) on a prescaler tick.
    function automatic state_t sweep_advance(input state_t st, input req_t sel);
        state_t nx;
        case (st)
            ST_L1:   nx = ST_L2;
            ST_L2:   nx = ST_L3;
            ST_L3:   nx = ST_GAP;
            ST_R1:   nx = ST_R2;
            ST_R2:   nx = ST_R3;
            ST_R3:   nx = ST_GAP;
            ST_GAP:  nx = entry_state(sel);
            default: nx = ST_IDLE;
        endcase
        return nx;
    endfunction

    function automatic logic is_sweep(input state_t st);
        logic hit;
        case (st)
            ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_GAP: hit = 1'b1;
            default:                                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [2:0] left_decode(input state_t st);
        logic [2:0] lamps;
        case (st)
            ST_L1:     lamps = LAMP_1;
            ST_L2:     lamps = LAMP_2;
            ST_L3:     lamps = LAMP_3;
            ST_HAZ_ON: lamps = LAMP_3;
            default:   lamps = LAMP_OFF;
        endcase
        return lamps;
    endfunction

    function automatic logic [2:0] right_decode(input state_t st);
        logic [2:0] lamps;
        case (st)
            ST_R1:     lamps = LAMP_1;
            ST_R2:     lamps = LAMP_2;
            ST_R3:     lamps = LAMP_3;
            ST_HAZ_ON: lamps = LAMP_3;
            default:   lamps = LAMP_OFF;
        endcase
        return lamps;
    endfunction

    // GAP keeps reporting the direction of the sweep that just finished.
    function automatic logic [1:0] mode_decode(input state_t st, input logic [1:0] prev);
        logic [1:0] m;
        case (st)
            ST_L1, ST_L2, ST_L3:   m = MODE_LEFT;
            ST_R1, ST_R2, ST_R3:   m = MODE_RIGHT;
            ST_HAZ_ON, ST_HAZ_OFF: m = MODE_HAZ;
            ST_GAP:                m = prev;
            default:               m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while running and emits a registered
// one-cycle tick aligned with the terminal count. A clear forces the count to 0.
module step_prescaler #(
    parameter int TICK_DIV = 5000000,
    parameter int CNT_W    = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM     = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             tick_r;

    // Next count: clear has priority, then wrap at the terminal value.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = CNT_ZERO;
        end else if (run) begin
            if (count_r == TERM) begin
                count_next_s = CNT_ZERO;
            end else begin
                count_next_s = count_r + CNT_ONE;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Tick is registered from the next count so it is high while count == TERM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            tick_r  <= (count_next_s == TERM);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/turn_signal_scheduler.sv
// Tail-light sequencing controller: synchronizes switch/key requests, arbitrates
// them, and runs the sweep/flash state machine paced by the step prescaler.
module turn_signal_scheduler
    import turn_signal_pkg::*;
#(
    parameter int TICK_DIV    = 5000000,
    parameter int CNT_W       = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic       ADC_CLK_10,
    input  logic       reset,
    input  logic       hazard_req,
    input  logic       turn_en,
    input  logic       left_req,
    input  logic       right_req,
    output logic [2:0] left_lamps,
    output logic [2:0] right_lamps,
    output logic [1:0] mode,
    output logic       step_tick,
    output logic       busy
);

    logic [SYNC_STAGES-1:0][3:0] sync_r;
    logic [3:0]                  req_raw_s;
    logic [3:0]                  req_sync_s;
    logic                        hazard_s;
    req_t                        req_sel_s;

    state_t     state_r;
    state_t     state_next_s;
    logic [2:0] left_r;
    logic [2:0] right_r;
    logic [1:0] mode_r;
    logic       busy_r;

    logic       tick_s;
    logic       preempt_s;
    logic       pre_clr_s;
    logic       pre_run_s;

    assign req_raw_s  = {hazard_req, turn_en, left_req, right_req};
    assign req_sync_s = sync_r[SYNC_STAGES-1];
    assign hazard_s   = req_sync_s[3];
    assign req_sel_s  = arbitrate(req_sync_s[3], req_sync_s[2], req_sync_s[1], req_sync_s[0]);

    // Multi-flop synchronizers for the four asynchronous request levels.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{4'b0000}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_raw_s};
        end
    end

    // The prescaler restarts on hazard preemption so the first flash is full length.
    assign preempt_s = hazard_s && is_sweep(state_r);
    assign pre_clr_s = (state_r == ST_IDLE) || preempt_s;
    assign pre_run_s = (state_r != ST_IDLE);

    step_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk  (ADC_CLK_10),
        .rst  (reset),
        .clr  (pre_clr_s),
        .run  (pre_run_s),
        .tick (tick_s)
    );

    // Next-state logic; sweeps ignore request changes until GAP re-arbitration.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = entry_state(req_sel_s);
            end
            ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_GAP: begin
                if (hazard_s) begin
                    state_next_s = ST_HAZ_ON;
                end else if (tick_s) begin
                    state_next_s = sweep_advance(state_r, req_sel_s);
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HAZ_ON: begin
                if (tick_s) begin
                    state_next_s = ST_HAZ_OFF;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HAZ_OFF: begin
                if (tick_s) begin
                    state_next_s = entry_state(req_sel_s);
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with Moore outputs decoded from the next state.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            left_r  <= LAMP_OFF;
            right_r <= LAMP_OFF;
            mode_r  <= MODE_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            left_r  <= left_decode(state_next_s);
            right_r <= right_decode(state_next_s);
            mode_r  <= mode_decode(state_next_s, mode_r);
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    assign left_lamps  = left_r;
    assign right_lamps = right_r;
    assign mode        = mode_r;
    assign busy        = busy_r;
    assign step_tick   = tick_s;

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Randomized scoreboard bench for turn_signal_scheduler against an activity/step
// reference model; a negedge monitor compares every cycle's outputs.
module tb_turn_signal_scheduler;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 23;
    localparam int SYNC     = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       hazard_req;
    logic       turn_en;
    logic       left_req;
    logic       right_req;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;
    logic [1:0] mode;
    logic       step_tick;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    // Expected {left, right, mode, busy, tick}
    logic [9:0] exp_q[$];

    // Reference model: activity 0 idle / 1 left / 2 right / 3 hazard,
    // step 0..2 lit sweep steps, 3 gap; hazard step 0 on, 1 off.
    int         act;
    int         step;
    int         cnt;
    logic [3:0] pipe[$];

    always #5 clk = ~clk;

    turn_signal_scheduler #(
        .TICK_DIV    (TICK_DIV),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .ADC_CLK_10  (clk),
        .reset       (reset),
        .hazard_req  (hazard_req),
        .turn_en     (turn_en),
        .left_req    (left_req),
        .right_req   (right_req),
        .left_lamps  (left_lamps),
        .right_lamps (right_lamps),
        .mode        (mode),
        .step_tick   (step_tick),
        .busy        (busy)
    );

    function automatic int choose(input logic [3:0] s);
        if (s[3]) return 3;
        else if (s[2] && s[1] && !s[0]) return 1;
        else if (s[2] && s[0] && !s[1]) return 2;
        else return 0;
    endfunction

    task automatic model_reset();
        act  = 0;
        step = 0;
        cnt  = 0;
        pipe.delete();
        repeat (SYNC) pipe.push_back(4'b0000);
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] s;
        int         sel;
        bit         tick;
        s    = pipe[0];
        tick = (act != 0) && (cnt == TICK_DIV - 1);
        sel  = choose(s);
        void'(pipe.pop_front());
        pipe.push_back(raw);
        if (act == 0) begin
            act  = sel;
            step = 0;
            cnt  = 0;
        end else if (act == 1 || act == 2) begin
            if (s[3]) begin
                act  = 3;
                step = 0;
                cnt  = 0;
            end else if (tick) begin
                cnt = 0;
                if (step < 3) step++;
                else begin
                    act  = sel;
                    step = 0;
                end
            end else begin
                cnt++;
            end
        end else begin
            if (tick) begin
                cnt = 0;
                if (step == 0) step = 1;
                else begin
                    act  = sel;
                    step = 0;
                end
            end else begin
                cnt++;
            end
        end
    endtask

    function automatic logic [9:0] expect_vec();
        logic [2:0] pat;
        logic [2:0] l;
        logic [2:0] r;
        pat = (step < 3) ? 3'((1 << (step + 1)) - 1) : 3'b000;
        l = 3'b000;
        r = 3'b000;
        if (act == 1) l = pat;
        if (act == 2) r = pat;
        if (act == 3 && step == 0) begin
            l = 3'b111;
            r = 3'b111;
        end
        return {l, r, 2'(act), (act != 0), ((act != 0) && (cnt == TICK_DIV - 1))};
    endfunction

    // Outputs must be at reset values while reset is held, before any clock edge.
    task automatic check_reset_state();
        logic [9:0] a;
        #1;
        a = {left_lamps, right_lamps, mode, busy, step_tick};
        n_cmp++;
        if (a !== 10'b000_000_00_0_0) begin
            n_bad++;
            $display("FAIL reset state @%0t: got left=%b right=%b mode=%b busy=%b tick=%b",
                     $time, a[9:7], a[6:4], a[3:2], a[1], a[0]);
        end
    endtask

    // One clock: model follows the edge using the inputs the DUT just sampled.
    task automatic run_cycle();
        logic [3:0] raw;
        @(posedge clk);
        raw = {hazard_req, turn_en, left_req, right_req};
        if (reset) model_reset();
        else model_edge(raw);
        exp_q.push_back(expect_vec());
        #1;
    endtask

    task automatic hold(input logic h, input logic t, input logic l, input logic r, input int n);
        hazard_req = h;
        turn_en    = t;
        left_req   = l;
        right_req  = r;
        repeat (n) run_cycle();
    endtask

    // Reset between edges: the outputs must already be at reset values at the next negedge.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(expect_vec());
        check_reset_state();
        run_cycle();
        run_cycle();
        reset = 1'b0;
    endtask

    // Monitor: pop and compare one expectation per cycle.
    initial begin
        logic [9:0] e;
        logic [9:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {left_lamps, right_lamps, mode, busy, step_tick};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got left=%b right=%b mode=%b busy=%b tick=%b, want left=%b right=%b mode=%b busy=%b tick=%b",
                             $time, a[9:7], a[6:4], a[3:2], a[1], a[0],
                             e[9:7], e[6:4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    // Watchdog: the stimulus sequence must finish within the time bound.
    initial begin
        #2000000;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout @%0t: stimulus did not complete", $time);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        reset      = 1'b1;
        hazard_req = 1'b0;
        turn_en    = 1'b0;
        left_req   = 1'b0;
        right_req  = 1'b0;
        model_reset();
        check_reset_state();
        repeat (3) run_cycle();
        reset = 1'b0;

        hold(1'b0, 1'b0, 1'b0, 1'b0, 4);
        hold(1'b0, 1'b1, 1'b1, 1'b0, 40);   // left sweeps with gaps
        hold(1'b0, 1'b1, 1'b0, 1'b0, 20);
        hold(1'b0, 1'b1, 1'b0, 1'b1, 10);   // right sweep, then direction change mid-sweep
        hold(1'b0, 1'b1, 1'b1, 1'b0, 30);
        hold(1'b1, 1'b1, 1'b1, 1'b0, 19);   // hazard preempts a left sweep
        hold(1'b0, 1'b1, 1'b1, 1'b0, 30);   // hazard withdrawn, left resumes
        hold(1'b0, 1'b0, 1'b0, 1'b0, 20);
        hold(1'b0, 1'b1, 1'b1, 1'b1, 40);   // both directions: stays idle
        hold(1'b0, 1'b1, 1'b1, 1'b0, 7);
        pulse_reset();                      // reset mid-count
        hold(1'b0, 1'b1, 1'b0, 1'b1, 25);
        hold(1'b0, 1'b0, 1'b0, 1'b1, 20);   // turn_en drop mid-sweep

        for (int seg = 0; seg < 80; seg++) begin
            logic [3:0] v;
            int         dur;
            v    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) v[3] = 1'b0;
            dur  = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 40);
            hold(v[3], v[2], v[1], v[0], dur);
            if ($urandom_range(0, 11) == 0) pulse_reset();
        end

        hold(1'b0, 1'b0, 1'b0, 1'b0, 40);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
